dense_serializer: RTL and testbench

Parallel-to-serial feeder for the integer dense layers. It accepts one N-element signed int8 vector per handshake, such as a dense layer's B-wide output. It then emits the elements one at a time as a valid-qualified int8 stream, holding each element for STRIDE cycles to match the serial consumer's 2-cycle-per-element input cadence. A two-slot ping-pong buffer lets a new vector be accepted while the current one drains, and consecutive vectors stream without bubbles.

---
 rtl/dense_serializer.sv | 143 ++++++++++++++
 tb/tb_dense_serializer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dense_serializer.sv
// dense_serializer: accepts one N-element vector per valid/ready handshake into a
// two-slot ping-pong buffer and streams the elements out one at a time, holding
// each element on data_o for STRIDE cycles. Consecutive vectors stream without bubbles.
module dense_serializer #(
    parameter int N          = 7,
    parameter int DATA_WIDTH = 8,
    parameter int STRIDE     = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    valid_i,
    input  logic [N*DATA_WIDTH-1:0] data_i,
    output logic                    ready_o,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic                    valid_o,
    output logic                    last_o,
    output logic                    busy_o
);

    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam int SCW  = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);
    localparam logic [SCW-1:0]  SC_LAST  = SCW'(STRIDE - 1);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              full_q, full_d;
    logic                    wr_q, wr_d;
    logic                    rd_q, rd_d;
    logic [IDXW-1:0]         idx_q, idx_d;
    logic [SCW-1:0]          sc_q, sc_d;
    logic [N*DATA_WIDTH-1:0] slot_q [2];
    logic [N*DATA_WIDTH-1:0] slot_d [2];
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    busy_q, busy_d;
    logic                    accept;

    // Combinational ready: a slot is free and the block is out of reset.
    assign ready_o = rstn && !(full_q[0] && full_q[1]);
    assign accept  = valid_i && ready_o;

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign busy_o  = busy_q;

    // Control and registered output state; reset discards both slots.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            full_q  <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            idx_q   <= '0;
            sc_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            full_q  <= full_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            idx_q   <= idx_d;
            sc_q    <= sc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    // Slot storage; contents are qualified by the full flags, so no reset needed.
    always_ff @(posedge clk) begin
        slot_q[0] <= slot_d[0];
        slot_q[1] <= slot_d[1];
    end

    // Accept path, output FSM, and next values of the registered outputs.
    always_comb begin
        state_d   = state_q;
        full_d    = full_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        idx_d     = idx_q;
        sc_d      = sc_q;
        slot_d[0] = slot_q[0];
        slot_d[1] = slot_q[1];
        data_d    = '0;
        valid_d   = 1'b0;
        last_d    = 1'b0;

        // wr always points at the free slot when ready_o is high, so an accept
        // never collides with the slot being released in the same edge.
        if (accept) begin
            slot_d[wr_q] = data_i;
            full_d[wr_q] = 1'b1;
            wr_d         = ~wr_q;
        end

        case (state_q)
            IDLE: begin
                if (full_q[rd_q]) begin
                    state_d = EMIT;
                    idx_d   = '0;
                    sc_d    = '0;
                end
            end
            EMIT: begin
                if (sc_q == SC_LAST) begin
                    sc_d = '0;
                    if (idx_q == IDX_LAST) begin
                        full_d[rd_q] = 1'b0;
                        rd_d         = ~rd_q;
                        idx_d        = '0;
                        state_d      = full_q[~rd_q] ? EMIT : IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    sc_d = sc_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are computed from the next state.
        if (state_d == EMIT) begin
            valid_d = 1'b1;
            data_d  = slot_q[rd_d][int'(idx_d)*DATA_WIDTH +: DATA_WIDTH];
            last_d  = (idx_d == IDX_LAST);
        end
        busy_d = full_d[0] || full_d[1];
    end

endmodule

// File: tb/tb_dense_serializer.sv
// Self-checking bench for dense_serializer: an occupancy/elapsed-time reference
// model for N=7, STRIDE=2 under directed and random traffic, plus a directed
// N=2, STRIDE=1 instance.
module tb_dense_serializer;

    localparam int N  = 7;
    localparam int S  = 2;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn;
    logic            valid_i;
    logic [N*DW-1:0] data_i;
    logic            ready_o;
    logic [DW-1:0]   data_o;
    logic            valid_o;
    logic            last_o;
    logic            busy_o;

    dense_serializer #(.N(N), .DATA_WIDTH(DW), .STRIDE(S)) dut (
        .clk(clk), .rstn(rstn), .valid_i(valid_i), .data_i(data_i),
        .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o),
        .last_o(last_o), .busy_o(busy_o)
    );

    logic          rstn2;
    logic          valid2_i;
    logic [15:0]   data2_i;
    logic          ready2_o;
    logic [DW-1:0] data2_o;
    logic          valid2_o;
    logic          last2_o;
    logic          busy2_o;

    dense_serializer #(.N(2), .DATA_WIDTH(DW), .STRIDE(1)) dut2 (
        .clk(clk), .rstn(rstn2), .valid_i(valid2_i), .data_i(data2_i),
        .ready_o(ready2_o), .data_o(data2_o), .valid_o(valid2_o),
        .last_o(last2_o), .busy_o(busy2_o)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: queue of held vectors, and how many cycles of the head
    // vector have been emitted so far.
    logic [N*DW-1:0] mq[$];
    bit              m_act = 1'b0;
    int              m_t   = 0;

    // One clock: drive at the negedge, check ready, update the model at the
    // posedge, check registered outputs at the following negedge.
    task automatic cycle(input bit r, input bit v, input logic [N*DW-1:0] d, output bit acc);
        logic [N*DW-1:0] head;
        int              e;
        rstn    = r;
        valid_i = v;
        data_i  = d;
        #1;
        check("ready", ready_o, r && (mq.size() < 2));
        acc = r && v && (mq.size() < 2);
        @(posedge clk);
        if (!r) begin
            mq.delete();
            m_act = 1'b0;
            m_t   = 0;
        end else begin
            if (m_act) begin
                m_t++;
                if (m_t == N*S) begin
                    void'(mq.pop_front());
                    m_t   = 0;
                    m_act = (mq.size() > 0);
                end
            end else if (mq.size() > 0) begin
                m_act = 1'b1;
                m_t   = 0;
            end
            if (acc) mq.push_back(d);
        end
        @(negedge clk);
        check("valid", valid_o, m_act);
        check("busy", busy_o, mq.size() > 0);
        e = m_t / S;
        check("last", last_o, m_act && (e == N-1));
        if (m_act) begin
            head = mq[0];
            check("data", data_o, head[e*DW +: DW]);
        end
        if (!r) check("data_rst", data_o, 0);
    endtask

    function automatic logic [N*DW-1:0] rand_vec();
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    bit              acc;
    bit              c_done;
    logic [N*DW-1:0] va, vb, vc;

    initial begin
        rstn = 1'b0; valid_i = 1'b0; data_i = '0;
        rstn2 = 1'b0; valid2_i = 1'b0; data2_i = '0;
        @(negedge clk);

        // Reset
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, acc);

        // Single vector {1,-2,3,-4,127,-128,0}
        va = {8'sd0, -8'sd128, 8'sd127, -8'sd4, 8'sd3, -8'sd2, 8'sd1};
        cycle(1'b1, 1'b1, va, acc);
        check("single_acc", acc, 1'b1);
        for (int i = 0; i < 17; i++) cycle(1'b1, 1'b0, '0, acc);

        // Back-to-back A, B, then C held until accepted after A releases
        va = rand_vec(); vb = rand_vec(); vc = rand_vec();
        cycle(1'b1, 1'b1, va, acc);
        cycle(1'b1, 1'b1, vb, acc);
        check("b2b_acc_b", acc, 1'b1);
        c_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cycle(1'b1, !c_done, vc, acc);
            if (acc) begin
                check("c_accept_cycle", i, 14);
                c_done = 1'b1;
            end
        end
        check("c_accepted", c_done, 1'b1);
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, '0, acc);

        // Reset mid-stream during element 3 of A with B queued
        cycle(1'b1, 1'b1, rand_vec(), acc);
        cycle(1'b1, 1'b1, rand_vec(), acc);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, '0, acc);
        cycle(1'b0, 1'b0, '0, acc);
        for (int i = 0; i < 35; i++) cycle(1'b1, 1'b0, '0, acc);

        // Random traffic with occasional resets
        for (int i = 0; i < 1500; i++)
            cycle($urandom_range(0, 249) != 0, $urandom_range(0, 3) == 0, rand_vec(), acc);
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, '0, acc);

        // N=2, STRIDE=1: {5,6} then {7,8}
        rstn2 = 1'b1;
        valid2_i = 1'b1; data2_i = {8'd6, 8'd5};
        #1 check("s1_ready0", ready2_o, 1'b1);
        @(negedge clk);
        data2_i = {8'd8, 8'd7};
        #1 check("s1_ready1", ready2_o, 1'b1);
        @(negedge clk);
        valid2_i = 1'b0;
        check("s1_v0", valid2_o, 1'b1); check("s1_d0", data2_o, 8'd5); check("s1_l0", last2_o, 1'b0);
        @(negedge clk);
        check("s1_v1", valid2_o, 1'b1); check("s1_d1", data2_o, 8'd6); check("s1_l1", last2_o, 1'b1);
        @(negedge clk);
        check("s1_v2", valid2_o, 1'b1); check("s1_d2", data2_o, 8'd7); check("s1_l2", last2_o, 1'b0);
        @(negedge clk);
        check("s1_v3", valid2_o, 1'b1); check("s1_d3", data2_o, 8'd8); check("s1_l3", last2_o, 1'b1);
        @(negedge clk);
        check("s1_v4", valid2_o, 1'b0); check("s1_busy4", busy2_o, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
